// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C master request arbiter.
package i2c_arb_pkg;

  localparam int unsigned DEVADR_W      = 7;
  localparam int unsigned REGADR_W      = 8;
  localparam int unsigned DATNUM_W      = 16;
  localparam int unsigned DAT_W         = 8;
  localparam int unsigned DEF_MIN_WAIT  = 7;
  localparam int unsigned DEF_START_TMO = 255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Transfer descriptor latched from the granted requester.
  typedef struct packed {
    logic                rw;
    logic                ur;
    logic [DEVADR_W-1:0] devadr;
    logic [REGADR_W-1:0] regadr;
    logic [DATNUM_W-1:0] datnum;
  } cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past the pointer and wraps.
module rr_arbiter #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] pointer,
  output logic [NREQ-1:0]  winner,
  output logic [IDX_W-1:0] idx
);

  int unsigned      cand;
  logic [IDX_W-1:0] cidx;
  logic             found;

  always_comb begin
    winner = '0;
    idx    = '0;
    cand   = 0;
    cidx   = '0;
    found  = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = (32'(pointer) + i) % NREQ;
      cidx = IDX_W'(cand);
      if (!found && req[cidx]) begin
        found        = 1'b1;
        winner[cidx] = 1'b1;
        idx          = cidx;
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one i2c_mmaster between NREQ requesters with round-robin arbitration,
// latching the winner's descriptor and routing data strobes back to it.
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned MIN_WAIT  = DEF_MIN_WAIT,
  parameter int unsigned START_TMO = DEF_START_TMO
) (
  input  logic                     clock_i,
  input  logic                     reset_ni,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ-1:0]          rw_i,
  input  logic [NREQ-1:0]          ur_i,
  input  logic [DEVADR_W*NREQ-1:0] devadr_i,
  input  logic [REGADR_W*NREQ-1:0] regadr_i,
  input  logic [DATNUM_W*NREQ-1:0] datnum_i,
  input  logic [DAT_W*NREQ-1:0]    wdat_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic [NREQ-1:0]          done_o,
  output logic [NREQ-1:0]          err_o,
  output logic [DAT_W-1:0]         rdat_o,
  output logic [NREQ-1:0]          dvalid_o,
  output logic [NREQ-1:0]          newdat_o,
  output logic                     m_enable_o,
  output logic                     m_rw_o,
  output logic                     m_ur_o,
  output logic [DEVADR_W-1:0]      m_devadr_o,
  output logic [REGADR_W-1:0]      m_regadr_o,
  output logic [DATNUM_W-1:0]      m_datnum_o,
  output logic [DAT_W-1:0]         m_dat_o,
  input  logic [DAT_W-1:0]         m_dat_i,
  input  logic                     m_busy_i,
  input  logic                     m_dvalid_i,
  input  logic                     m_newdat_i
);

  localparam int unsigned IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_MAX = (START_TMO > MIN_WAIT) ? START_TMO : MIN_WAIT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic [DEVADR_W-1:0] devadr_a [NREQ];
  logic [REGADR_W-1:0] regadr_a [NREQ];
  logic [DATNUM_W-1:0] datnum_a [NREQ];
  logic [DAT_W-1:0]    wdat_a   [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign devadr_a[k] = devadr_i[DEVADR_W*k +: DEVADR_W];
    assign regadr_a[k] = regadr_i[REGADR_W*k +: REGADR_W];
    assign datnum_a[k] = datnum_i[DATNUM_W*k +: DATNUM_W];
    assign wdat_a[k]   = wdat_i[DAT_W*k +: DAT_W];
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [NREQ-1:0]  err_q, err_d;
  logic             en_q, en_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cmd_t             cmd_q, cmd_d;

  logic [NREQ-1:0]  win;
  logic [IDX_W-1:0] win_idx;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req     (req_i),
    .pointer (ptr_q),
    .winner  (win),
    .idx     (win_idx)
  );

  // State and registered outputs.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      ptr_q   <= IDX_W'(NREQ - 1);
      sel_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
    end
  end

  // Next state; done/err are computed on the edge into DONE so they last one cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = '0;
    en_d    = en_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          state_d      = ST_GRANT;
          gnt_d        = win;
          ptr_d        = win_idx;
          sel_d        = win_idx;
          cmd_d.rw     = rw_i[win_idx];
          cmd_d.ur     = ur_i[win_idx];
          cmd_d.devadr = devadr_a[win_idx];
          cmd_d.regadr = regadr_a[win_idx];
          cmd_d.datnum = datnum_a[win_idx];
        end
      end
      ST_GRANT: begin
        if (cmd_q.datnum == '0) begin
          state_d = ST_DONE;
          done_d  = gnt_q;
          err_d   = gnt_q;
        end else begin
          state_d = ST_START;
          en_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (m_busy_i) begin
          state_d = ST_RUN;
          en_d    = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(START_TMO - 1)) begin
          state_d = ST_DONE;
          en_d    = 1'b0;
          done_d  = gnt_q;
          err_d   = gnt_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        // Ignore an early low busy until the master has had MIN_WAIT cycles to respond.
        if (cnt_q == CNT_W'(MIN_WAIT)) begin
          if (!m_busy_i) begin
            state_d = ST_DONE;
            done_d  = gnt_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign gnt_o      = gnt_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign m_enable_o = en_q;
  assign m_rw_o     = cmd_q.rw;
  assign m_ur_o     = cmd_q.ur;
  assign m_devadr_o = cmd_q.devadr;
  assign m_regadr_o = cmd_q.regadr;
  assign m_datnum_o = cmd_q.datnum;

  // Data path pass-through to and from the granted requester.
  assign m_dat_o  = wdat_a[sel_q];
  assign rdat_o   = m_dat_i;
  assign dvalid_o = {NREQ{m_dvalid_i}} & gnt_q;
  assign newdat_o = {NREQ{m_newdat_i}} & gnt_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Self-checking bench for i2c_req_arbiter with a transaction-level model and emulated master.
module tb_i2c_req_arbiter;

  localparam int NREQ      = 2;
  localparam int MIN_WAIT  = 7;
  localparam int START_TMO = 8;

  logic        clock_i = 1'b0;
  logic        reset_ni;
  logic [1:0]  req_i, rw_i, ur_i;
  logic [13:0] devadr_i;
  logic [15:0] regadr_i;
  logic [31:0] datnum_i;
  logic [15:0] wdat_i;
  logic [1:0]  gnt_o, done_o, err_o, dvalid_o, newdat_o;
  logic [7:0]  rdat_o, m_dat_o, m_dat_i;
  logic        m_enable_o, m_rw_o, m_ur_o;
  logic [6:0]  m_devadr_o;
  logic [7:0]  m_regadr_o;
  logic [15:0] m_datnum_o;
  logic        m_busy_i, m_dvalid_i, m_newdat_i;

  int total = 0;
  int bad   = 0;
  int last_w;

  always #5 clock_i = ~clock_i;

  i2c_req_arbiter #(
    .NREQ      (NREQ),
    .MIN_WAIT  (MIN_WAIT),
    .START_TMO (START_TMO)
  ) dut (
    .clock_i    (clock_i),
    .reset_ni   (reset_ni),
    .req_i      (req_i),
    .rw_i       (rw_i),
    .ur_i       (ur_i),
    .devadr_i   (devadr_i),
    .regadr_i   (regadr_i),
    .datnum_i   (datnum_i),
    .wdat_i     (wdat_i),
    .gnt_o      (gnt_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .rdat_o     (rdat_o),
    .dvalid_o   (dvalid_o),
    .newdat_o   (newdat_o),
    .m_enable_o (m_enable_o),
    .m_rw_o     (m_rw_o),
    .m_ur_o     (m_ur_o),
    .m_devadr_o (m_devadr_o),
    .m_regadr_o (m_regadr_o),
    .m_datnum_o (m_datnum_o),
    .m_dat_o    (m_dat_o),
    .m_dat_i    (m_dat_i),
    .m_busy_i   (m_busy_i),
    .m_dvalid_i (m_dvalid_i),
    .m_newdat_i (m_newdat_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic set_desc(input int k, input logic rw, input logic ur, input logic [6:0] dev,
                          input logic [7:0] rg, input logic [15:0] dn, input logic [7:0] wd);
    rw_i[k]               = rw;
    ur_i[k]               = ur;
    devadr_i[7*k +: 7]    = dev;
    regadr_i[8*k +: 8]    = rg;
    datnum_i[16*k +: 16]  = dn;
    wdat_i[8*k +: 8]      = wd;
  endtask

  task automatic rand_desc(input int k);
    logic [15:0] dn;
    dn = ($urandom_range(0, 6) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
    set_desc(k, 1'($urandom), 1'($urandom), 7'($urandom), 8'($urandom), dn, 8'($urandom));
  endtask

  // One arbitration + transfer. lat: enable cycles before the master raises busy
  // (0 = never), blen: busy cycles, ndv: dvalid pulses issued during busy.
  task automatic do_txn(input logic [1:0] reqv, input int lat, input int blen,
                        input int ndv, input bit drop_mid);
    int w, en_cnt, last_en, dv_seen, dv_other, bleft, dvleft, gnt_bad, exp_gap, exp_en;
    bit started, done_seen, e_err;
    logic [1:0]  oh;
    logic        e_rw, e_ur;
    logic [6:0]  e_dev;
    logic [7:0]  e_reg, e_wd;
    logic [15:0] e_dn;
    w = -1; en_cnt = 0; last_en = 0; dv_seen = 0; dv_other = 0; bleft = 0; dvleft = 0;
    gnt_bad = 0; started = 0; done_seen = 0;

    @(negedge clock_i);
    chk("idle_gnt", 32'(gnt_o), 32'd0);
    chk("idle_done", 32'(done_o), 32'd0);
    req_i = reqv;
    for (int i = 1; i <= NREQ; i++)
      if (w < 0 && reqv[(last_w + i) % NREQ]) w = (last_w + i) % NREQ;
    last_w = w;
    oh    = 2'(1 << w);
    e_rw  = rw_i[w];
    e_ur  = ur_i[w];
    e_dev = devadr_i[7*w +: 7];
    e_reg = regadr_i[8*w +: 8];
    e_dn  = datnum_i[16*w +: 16];
    e_wd  = wdat_i[8*w +: 8];
    e_err = (e_dn == 16'd0) || (lat == 0);

    for (int c = 1; c <= 600; c++) begin
      @(negedge clock_i);
      if (c == 1) begin
        chk("grant", 32'(gnt_o), 32'(oh));
        chk("m_rw", 32'(m_rw_o), 32'(e_rw));
        chk("m_ur", 32'(m_ur_o), 32'(e_ur));
        chk("m_devadr", 32'(m_devadr_o), 32'(e_dev));
        chk("m_regadr", 32'(m_regadr_o), 32'(e_reg));
        chk("m_datnum", 32'(m_datnum_o), 32'(e_dn));
      end
      if (c == 2) begin
        rw_i = 2'($urandom); ur_i = 2'($urandom); devadr_i = 14'($urandom);
        regadr_i = 16'($urandom); datnum_i = $urandom;
        if (drop_mid) req_i = 2'b00;
      end
      if (done_o != 2'b00) begin
        done_seen = 1;
        exp_en  = (e_dn == 16'd0) ? 0 : (lat == 0) ? START_TMO : lat;
        exp_gap = (e_dn == 16'd0) ? 2 : (lat == 0) ? 1 : imax(MIN_WAIT, blen - 1) + 2;
        chk("done", 32'(done_o), 32'(oh));
        chk("err", 32'(err_o), e_err ? 32'(oh) : 32'd0);
        chk("gnt_at_done", 32'(gnt_o), 32'(oh));
        chk("devadr_hold", 32'(m_devadr_o), 32'(e_dev));
        chk("datnum_hold", 32'(m_datnum_o), 32'(e_dn));
        chk("enable_cycles", 32'(en_cnt), 32'(exp_en));
        chk("done_latency", (e_dn == 16'd0) ? 32'(c) : 32'(c - last_en), 32'(exp_gap));
        chk("dvalid_count", 32'(dv_seen), (e_err) ? 32'd0 : 32'(ndv));
        chk("dvalid_other", 32'(dv_other), 32'd0);
        chk("gnt_stable", 32'(gnt_bad), 32'd0);
        m_busy_i = 1'b0; m_dvalid_i = 1'b0; m_newdat_i = 1'b0;
        break;
      end
      if (gnt_o !== oh) gnt_bad++;
      if (m_enable_o) begin en_cnt++; last_en = c; end
      if (!started && lat != 0 && m_enable_o && en_cnt == lat) begin
        started = 1; m_busy_i = 1'b1; bleft = blen; dvleft = ndv;
      end else if (m_busy_i) begin
        bleft--;
        if (bleft == 0) m_busy_i = 1'b0;
      end
      m_dvalid_i = m_busy_i && (dvleft > 0) && !m_dvalid_i;
      if (m_dvalid_i) dvleft--;
      m_newdat_i = 1'($urandom);
      m_dat_i    = 8'($urandom);
      #1;
      if (dvalid_o[w]) dv_seen++;
      if (dvalid_o[1-w]) dv_other++;
      chk("dvalid_route", 32'(dvalid_o), m_dvalid_i ? 32'(oh) : 32'd0);
      chk("newdat_route", 32'(newdat_o), m_newdat_i ? 32'(oh) : 32'd0);
      chk("rdat", 32'(rdat_o), 32'(m_dat_i));
      chk("m_dat", 32'(m_dat_o), 32'(e_wd));
    end
    if (!done_seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int blen;
    reset_ni = 1'b0; req_i = '0; rw_i = '0; ur_i = '0; devadr_i = '0; regadr_i = '0;
    datnum_i = '0; wdat_i = '0; m_dat_i = '0; m_busy_i = 1'b0; m_dvalid_i = 1'b0;
    m_newdat_i = 1'b0; last_w = NREQ - 1;
    repeat (3) @(negedge clock_i);
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_en", 32'(m_enable_o), 32'd0);
    chk("rst_cmd", {m_rw_o, m_ur_o, m_devadr_o, m_regadr_o, m_datnum_o}, 32'd0);
    reset_ni = 1'b1;

    // Contention: both requesting continuously.
    set_desc(0, 1'b0, 1'b1, 7'h21, 8'h10, 16'd3, 8'h5A);
    set_desc(1, 1'b1, 1'b0, 7'h42, 8'h20, 16'd2, 8'hC3);
    for (int i = 0; i < 4; i++) begin
      set_desc(0, 1'b0, 1'b1, 7'h21, 8'(8'h10 + i), 16'd3, 8'h5A);
      set_desc(1, 1'b1, 1'b0, 7'h42, 8'(8'h20 + i), 16'd2, 8'hC3);
      do_txn(2'b11, 2, 3, 1, 1'b0);
    end

    // Single write request on requester 0.
    set_desc(0, 1'b0, 1'b0, 7'h50, 8'hA0, 16'd1, 8'h77);
    do_txn(2'b01, 3, 4, 0, 1'b0);

    // Zero-length on requester 1.
    set_desc(1, 1'b0, 1'b1, 7'h33, 8'h44, 16'd0, 8'h11);
    do_txn(2'b10, 2, 3, 0, 1'b0);

    // Start timeout: busy never rises.
    set_desc(0, 1'b1, 1'b0, 7'h12, 8'h34, 16'd9, 8'h99);
    do_txn(2'b01, 0, 0, 0, 1'b0);

    // Read routing: four dvalid pulses to requester 1; request dropped mid-transfer.
    set_desc(1, 1'b1, 1'b1, 7'h50, 8'hB0, 16'd4, 8'hE1);
    do_txn(2'b10, 1, 9, 4, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 30; i++) begin
      rand_desc(0);
      rand_desc(1);
      blen = $urandom_range(1, 14);
      do_txn(2'($urandom_range(1, 3)), $urandom_range(0, 5), blen,
             $urandom_range(0, (blen + 1) / 2), 1'($urandom));
    end

    // Reset while the master is busy in RUN.
    @(negedge clock_i);
    set_desc(1, 1'b1, 1'b1, 7'h7F, 8'hFF, 16'd5, 8'h3C);
    req_i = 2'b10;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock_i);
      if (m_enable_o) break;
    end
    chk("pre_rst_enable", 32'(m_enable_o), 32'd1);
    m_busy_i = 1'b1;
    repeat (3) @(negedge clock_i);
    chk("pre_rst_gnt", 32'(gnt_o), 32'd2);
    m_dvalid_i = 1'b1; m_newdat_i = 1'b1;
    reset_ni = 1'b0;
    #1;
    chk("abort_gnt", 32'(gnt_o), 32'd0);
    chk("abort_done_err", {done_o, err_o}, 32'd0);
    chk("abort_en", 32'(m_enable_o), 32'd0);
    chk("abort_cmd", {m_rw_o, m_ur_o, m_devadr_o, m_regadr_o, m_datnum_o}, 32'd0);
    chk("abort_route", {dvalid_o, newdat_o}, 32'd0);
    m_busy_i = 1'b0; m_dvalid_i = 1'b0; m_newdat_i = 1'b0; req_i = 2'b00;
    last_w = NREQ - 1;
    @(negedge clock_i);
    reset_ni = 1'b1;
    set_desc(0, 1'b0, 1'b0, 7'h01, 8'h02, 16'd1, 8'h03);
    set_desc(1, 1'b1, 1'b0, 7'h04, 8'h05, 16'd1, 8'h06);
    do_txn(2'b11, 1, 2, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
Shares one i2c_mmaster instance between NREQ independent requesters, for example the EEPROM test controller and a sensor poller. Arbitration is round-robin. The block latches the granted requester's transfer descriptor, drives the master's enable/command inputs, and routes write-data, dvalid and newdat between the master and the granted requester. It signals per-requester completion and error. It sits between the requester logic and i2c_mmaster, clocked on the I2C clock domain (nclk).

Parameters:
NREQ, 2, number of requesters (2..4)
MIN_WAIT, 7, minimum cycles in RUN before busy_i low may end a transfer
START_TMO, 255, cycles allowed in START for busy_i to rise before the transfer is errored

Ports:
clock_i  in  1  I2C-domain clock (nclk)
reset_ni  in  1  asynchronous reset, active-low
req_i  in  NREQ  per-requester transfer request, level
rw_i  in  NREQ  per-requester op code (1 = read)
ur_i  in  NREQ  per-requester use-register flag
devadr_i  in  7*NREQ  device addresses, slice k = [7k+6:7k]
regadr_i  in  8*NREQ  register addresses
datnum_i  in  16*NREQ  byte counts
wdat_i  in  8*NREQ  write data, one byte per requester
gnt_o  out  NREQ  one-hot grant
done_o  out  NREQ  one-cycle completion pulse
err_o  out  NREQ  one-cycle error pulse, coincident with done_o
rdat_o  out  8  read data, copy of master dat_o
dvalid_o  out  NREQ  master dvalid routed to the granted requester only
newdat_o  out  NREQ  master newdat routed to the granted requester only
m_enable_o  out  1  to master enable_i
m_rw_o, m_ur_o  out  1 each  to master rw_i, ur_i
m_devadr_o  out  7  to master devadr_i
m_regadr_o  out  8  to master regadr_i
m_datnum_o  out  16  to master datnum_i
m_dat_o  out  8  to master dat_i = wdat_i slice of the granted requester (combinational mux)
m_dat_i  in  8  from master dat_o
m_busy_i, m_dvalid_i, m_newdat_i  in  1 each  from master

Behaviour:
- Reset (asynchronous, reset_ni low): state IDLE.
  - All outputs 0: gnt_o, done_o, err_o, m_enable_o, m_rw_o, m_ur_o, m_devadr_o, m_regadr_o, m_datnum_o.
  - rr pointer = NREQ-1, so requester 0 wins first.
  - Asserting reset mid-transfer aborts immediately. The master must share the same reset.
- State machine:
  - IDLE: when any req_i is high, pick a winner round-robin starting at pointer+1 (wrap modulo NREQ), then go to GRANT.
  - GRANT (1 cycle):
    - gnt_o[k] = 1 and held through DONE.
    - Latch rw/ur/devadr/regadr/datnum of k into the m_* registers; pointer = k.
    - If datnum slice == 0, go to DONE with error. Otherwise go to START.
  - START:
    - m_enable_o = 1 and a counter runs.
    - When m_busy_i is seen high, drop m_enable_o on the next edge and go to RUN.
    - If the counter reaches START_TMO with busy never seen, drop enable and go to DONE with error.
  - RUN:
    - The wait counter saturates at MIN_WAIT.
    - When the counter equals MIN_WAIT and m_busy_i is low, go to DONE.
  - DONE (1 cycle):
    - done_o[k] = 1; err_o[k] = 1 if error.
    - gnt_o and the error flag clear on exit. Return to IDLE.
- Arbitration results:
  - The earliest arbitration after DONE is the IDLE cycle that follows, i.e. 2 cycles after DONE.
  - The requester must drop req_i on the cycle after done_o. A req_i still high at the next arbitration is a new request, ranked last by the rotated pointer.
  - With all requesters continuously requesting, grants rotate 0,1,..,NREQ-1,0.
- Routing:
  - dvalid_o[k] = m_dvalid_i & gnt_o[k]; newdat_o[k] = m_newdat_i & gnt_o[k]; all other bits 0.
  - rdat_o is unregistered pass-through.
- Descriptor and request changes:
  - Descriptor inputs are ignored after GRANT.
  - req_i dropping mid-transfer does not abort; the transfer completes and done_o is still pulsed.
  - m_* command outputs hold their latched values until the next GRANT.

Decomposition:
- Package i2c_arb_pkg holds:
  - state encoding IDLE/GRANT/START/RUN/DONE
  - default MIN_WAIT and START_TMO
  - field widths: DEVADR_W=7, REGADR_W=8, DATNUM_W=16, DAT_W=8
- One sub-module, rr_arbiter: parameter NREQ; inputs req, pointer; outputs one-hot winner and index.
  - Purely combinational, for standalone unit testing.
- The pointer register stays in i2c_req_arbiter.

Test Plan:
- Single request: req_i=01 carrying devadr 0x50, regadr 0xA0, datnum 1, rw 0. Required: gnt_o=01 the cycle after req, m_enable_o high until busy rises, done_o=01 pulses once after busy falls, err_o=00.
- Contention: req_i=11 held continuously, NREQ=2. Required: grant sequence 0,1,0,1 with no overlap, and each done pulses only its own bit.
- Zero length: datnum=0 on requester 1. Required: GRANT then DONE with done_o=10 and err_o=10; m_enable_o never asserts.
- Start timeout: master busy tied 0, START_TMO=8. Required: m_enable_o high for 8 cycles, then done_o and err_o pulse for the granted requester.
- Routing: read transfer of 4 bytes for requester 1 with master pulsing dvalid 4 times. Required: dvalid_o[1] pulses 4 times, dvalid_o[0] stays 0, rdat_o tracks m_dat_i.
- Reset mid-RUN: pull reset_ni low while busy. Required: all outputs 0 at once; after release, requester 0 wins first.
